// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the restoring divider.
// The iteration counter must hold 0..2*WIDTH inclusive.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } div_state_t;

   localparam int DIV_DEFAULT_WIDTH = 24;

   function automatic int div_cnt_w(input int width);
      return $clog2(2 * width + 1);
   endfunction

   localparam int DIV_CNT_W = div_cnt_w(DIV_DEFAULT_WIDTH);

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// then subtract the divisor if it fits.
module div_step #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] divisor_ext;
   logic [WIDTH:0] diff;

   // rem_in is always below the divisor, so its top bit is zero and
   // the shifted value still fits in WIDTH+1 bits.
   always_comb begin
      shifted     = {rem_in[WIDTH-1:0], bit_in};
      divisor_ext = {1'b0, divisor};
      diff        = shifted - divisor_ext;
      q_bit       = (shifted >= divisor_ext);
      rem_out     = q_bit ? diff : shifted;
   end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, with a start/ready/done handshake.
module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 div_by_zero
);

   localparam int CNT_W = div_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * WIDTH - 1);

   div_state_t          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [2*WIDTH-1:0]  dvd_q;
   logic [2*WIDTH-1:0]  quo_q;
   logic [WIDTH:0]      prem_q;
   logic [WIDTH-1:0]    dvsr_q;
   logic                dz_pend_q;

   logic                accept;
   logic                last_step;
   logic                dz_fire;
   logic [WIDTH:0]      step_rem;
   logic                step_q;

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in  (prem_q),
      .bit_in  (dvd_q[2*WIDTH-1]),
      .divisor (dvsr_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      last_step = 1'b0;
      dz_fire   = 1'b0;
      ready     = (state_q == IDLE);
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_q == LAST_STEP) begin
               last_step = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            // A zero divisor skips RUN; its results are published on the
            // way out of DONE so done lands two cycles after acceptance.
            dz_fire = dz_pend_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q       <= '0;
         dvd_q       <= '0;
         quo_q       <= '0;
         prem_q      <= '0;
         dvsr_q      <= '0;
         dz_pend_q   <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= last_step | dz_fire;

         if (accept) begin
            dvd_q     <= dividend;
            dvsr_q    <= divisor;
            prem_q    <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            dz_pend_q <= (divisor == '0);
         end else if (state_q == RUN) begin
            dvd_q  <= {dvd_q[2*WIDTH-2:0], 1'b0};
            prem_q <= step_rem;
            quo_q  <= {quo_q[2*WIDTH-2:0], step_q};
            cnt_q  <= cnt_q + CNT_W'(1);
         end

         if (last_step) begin
            quotient    <= {quo_q[2*WIDTH-2:0], step_q};
            remainder   <= step_rem[WIDTH-1:0];
            div_by_zero <= 1'b0;
         end else if (dz_fire) begin
            quotient    <= '1;
            remainder   <= dvd_q[WIDTH-1:0];
            div_by_zero <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: vector table, handshake corner cases
// and randomized operands against a plain-arithmetic reference.
module tb_divider;

   localparam int W  = 24;
   localparam int W2 = 2 * W;
   localparam int NORM_LAT = W2 + 1;
   localparam int DZ_LAT   = 2;

   typedef struct {
      logic [W2-1:0] a;
      logic [W-1:0]  b;
      logic [W2-1:0] q;
      logic [W-1:0]  r;
      logic          dz;
   } vec_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [W2-1:0] dividend;
   logic [W-1:0]  divisor;
   logic          ready;
   logic          done;
   logic [W2-1:0] quotient;
   logic [W-1:0]  remainder;
   logic          div_by_zero;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W2-1:0] prev_q;
   logic [W-1:0]  prev_r;
   logic          prev_dz;

   divider #(
      .WIDTH(W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .ready       (ready),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic void ref_div(input logic [W2-1:0] a, input logic [W-1:0] b,
                                   output logic [W2-1:0] q, output logic [W-1:0] r,
                                   output logic dz);
      if (b == 0) begin
         q  = '1;
         r  = a[W-1:0];
         dz = 1'b1;
      end else begin
         q  = a / W2'(b);
         r  = W'(a % W2'(b));
         dz = 1'b0;
      end
   endfunction

   task automatic wait_ready();
      int k = 0;
      while (!ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!ready) check("ready_timeout", 64'(ready), 64'd1);
   endtask

   // Leaves the caller at the first negedge after the accepting edge.
   task automatic issue(input logic [W2-1:0] a, input logic [W-1:0] b);
      wait_ready();
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = {$urandom, $urandom};
      divisor  = W'($urandom);
      check("ready_low_after_accept", 64'(ready), 64'd0);
   endtask

   task automatic wait_done(input int k0, output int lat);
      int k = k0;
      logic stable = 1'b1;
      while (!done && k < 300) begin
         if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_dz)
            stable = 1'b0;
         @(negedge clk);
         k++;
      end
      lat = done ? k : -1;
      check("outputs_held_while_busy", 64'(stable), 64'd1);
   endtask

   task automatic run_check(input string name, input logic [W2-1:0] a, input logic [W-1:0] b,
                            input logic [W2-1:0] eq, input logic [W-1:0] er, input logic edz);
      int lat;
      issue(a, b);
      wait_done(1, lat);
      check({name, "_latency"}, 64'(lat), edz ? 64'(DZ_LAT) : 64'(NORM_LAT));
      check({name, "_quotient"}, 64'(quotient), 64'(eq));
      check({name, "_remainder"}, 64'(remainder), 64'(er));
      check({name, "_div_by_zero"}, 64'(div_by_zero), 64'(edz));
      prev_q  = eq;
      prev_r  = er;
      prev_dz = edz;
      @(negedge clk);
      check({name, "_done_single_pulse"}, 64'(done), 64'd0);
      check({name, "_ready_after"}, 64'(ready), 64'd1);
   endtask

   vec_t vecs[9];

   initial begin
      int lat;
      int cnt;
      int done_k[$];
      logic [W2-1:0] got_q[$];
      logic [W-1:0]  got_r[$];
      logic [W2-1:0] mq;
      logic [W-1:0]  mr;
      logic          mdz;
      logic [W2-1:0] ra;
      logic [W-1:0]  rb;

      vecs[0] = '{48'd100, 24'd7, 48'd14, 24'd2, 1'b0};
      vecs[1] = '{48'h00_0000_1234, 24'd0, 48'hFFFF_FFFF_FFFF, 24'h001234, 1'b1};
      vecs[2] = '{48'hFFFF_FFFF_FFFF, 24'd1, 48'hFFFF_FFFF_FFFF, 24'd0, 1'b0};
      vecs[3] = '{48'd5, 24'hFF_FFFF, 48'd0, 24'd5, 1'b0};
      vecs[4] = '{48'd640, 24'd32, 48'd20, 24'd0, 1'b0};
      vecs[5] = '{48'd0, 24'd5, 48'd0, 24'd0, 1'b0};
      vecs[6] = '{48'hFFFF_FFFF_FFFF, 24'hFF_FFFF, 48'h0000_0100_0001, 24'd0, 1'b0};
      vecs[7] = '{48'hAB_CDEF_1234_56, 24'd0, 48'hFFFF_FFFF_FFFF, 24'h123456, 1'b1};
      vecs[8] = '{48'd1_000_003, 24'd1000, 48'd1000, 24'd3, 1'b0};

      rst      = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      prev_q   = '0;
      prev_r   = '0;
      prev_dz  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_done", 64'(done), 64'd0);
      check("reset_quotient", 64'(quotient), 64'd0);
      check("reset_remainder", 64'(remainder), 64'd0);
      check("reset_div_by_zero", 64'(div_by_zero), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++)
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

      // Busy lockout: a second request at RUN cycle 10 must be dropped.
      issue(48'd640, 24'd32);
      repeat (9) @(negedge clk);
      dividend = 48'd9;
      divisor  = 24'd3;
      start    = 1'b1;
      check("busy_ready_low", 64'(ready), 64'd0);
      @(negedge clk);
      start = 1'b0;
      wait_done(11, lat);
      check("busy_latency", 64'(lat), 64'(NORM_LAT));
      check("busy_quotient", 64'(quotient), 64'd20);
      check("busy_remainder", 64'(remainder), 64'd0);
      prev_q  = 48'd20;
      prev_r  = 24'd0;
      prev_dz = 1'b0;
      cnt = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("busy_no_extra_done", 64'(cnt), 64'd0);

      // Reset mid-run.
      issue(48'd1000, 24'd3);
      repeat (19) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_ready", 64'(ready), 64'd1);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_quotient", 64'(quotient), 64'd0);
      check("midrst_remainder", 64'(remainder), 64'd0);
      check("midrst_div_by_zero", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      prev_q  = '0;
      prev_r  = '0;
      prev_dz = 1'b0;
      cnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("midrst_no_done", 64'(cnt), 64'd0);
      run_check("after_rst", 48'd50, 24'd6, 48'd8, 24'd2, 1'b0);

      // Back-to-back with start held high.
      wait_ready();
      dividend = 48'd17;
      divisor  = 24'd4;
      start    = 1'b1;
      @(negedge clk);
      dividend = 48'd99;
      divisor  = 24'd10;
      for (int k = 1; k <= 150; k++) begin
         if (done) begin
            done_k.push_back(k);
            got_q.push_back(quotient);
            got_r.push_back(remainder);
         end
         if (k == 51) start = 1'b0;
         @(negedge clk);
      end
      check("b2b_done_count", 64'(done_k.size()), 64'd2);
      if (done_k.size() == 2) begin
         check("b2b_first_latency", 64'(done_k[0]), 64'(NORM_LAT));
         check("b2b_spacing", 64'(done_k[1] - done_k[0]), 64'(W2 + 2));
         check("b2b_q0", 64'(got_q[0]), 64'd4);
         check("b2b_r0", 64'(got_r[0]), 64'd1);
         check("b2b_q1", 64'(got_q[1]), 64'd9);
         check("b2b_r1", 64'(got_r[1]), 64'd9);
      end
      prev_q  = quotient;
      prev_r  = remainder;
      prev_dz = div_by_zero;

      // Randomized operands against the reference.
      for (int i = 0; i < 40; i++) begin
         ra = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = W'($urandom_range(1, 255));
            3:       ra = W2'($urandom);
            default: rb = W'($urandom);
         endcase
         if (i % 8 == 3) rb = W'($urandom_range(1, 1000));
         ref_div(ra, rb, mq, mr, mdz);
         run_check($sformatf("rand%0d", i), ra, rb, mq, mr, mdz);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
